// File: rtl/bit_reverse_stream.sv
// Streaming bit/group permutation stage with a one-deep skid buffer.
// in_ready is registered so the upstream handshake never depends on out_ready.
module bit_reverse_stream #(
  parameter int DATA_W  = 8,   // even, >= 2
  parameter int GROUP_W = 1,   // must divide DATA_W
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int N_GROUPS = DATA_W / GROUP_W;
  localparam int HALF_W   = DATA_W / 2;

  logic [DATA_W-1:0] w_bit_rev;
  logic [DATA_W-1:0] w_grp_rev;
  logic [DATA_W-1:0] w_half_swap;
  logic [DATA_W-1:0] w_perm;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_free;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_beat_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit_rev
      assign w_bit_rev[gi] = in_data[DATA_W-1-gi];
    end
    for (gi = 0; gi < N_GROUPS; gi++) begin : g_grp_rev
      assign w_grp_rev[gi*GROUP_W +: GROUP_W] = in_data[(N_GROUPS-1-gi)*GROUP_W +: GROUP_W];
    end
  endgenerate

  assign w_half_swap = {in_data[HALF_W-1:0], in_data[DATA_W-1:HALF_W]};

  always_comb begin
    w_perm = in_data;
    case (in_mode)
      2'b00:   w_perm = in_data;
      2'b01:   w_perm = w_bit_rev;
      2'b10:   w_perm = w_grp_rev;
      default: w_perm = w_half_swap;
    endcase
  end

  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;
  // Main register can take a new word when it is empty or draining this edge.
  assign w_main_free = w_out_xfer | ~r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          // in_ready is low here, so no new beat competes with the skid word.
          r_out_data   <= r_skid_data;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_in_xfer) begin
          r_out_data  <= w_perm;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        r_skid_data  <= w_perm;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
      if (w_out_xfer) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_bit_reverse_stream.sv
// Scoreboard bench: drivers push expected words, negedge monitors pop and compare.
// Two instances cover the 8-bit/4-bit-group and 16-bit/8-bit-group configurations.
module tb_bit_reverse_stream;

  localparam int PERIOD = 10;

  logic clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data, a_out_data;
  logic [1:0]  a_in_mode;
  logic [3:0]  a_beat_cnt;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_in_mode;
  logic [15:0] b_beat_cnt;

  bit_reverse_stream #(.DATA_W(8), .GROUP_W(4), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .beat_cnt(a_beat_cnt)
  );

  bit_reverse_stream #(.DATA_W(16), .GROUP_W(8), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .beat_cnt(b_beat_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_a[$];
  logic [15:0] exp_b[$];
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data;
  logic [7:0]  head_a;
  logic [15:0] head_b;
  logic        stress_done;

  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    logic [7:0] e;
  } vec_a_t;
  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [15:0] e;
  } vec_b_t;

  vec_a_t tbl_a[7] = '{
    '{8'hA5, 2'b10, 8'h5A}, '{8'hA5, 2'b11, 8'h5A}, '{8'hA5, 2'b00, 8'hA5},
    '{8'h0F, 2'b01, 8'hF0}, '{8'hC1, 2'b01, 8'h83}, '{8'h12, 2'b10, 8'h21},
    '{8'h3C, 2'b11, 8'hC3}
  };
  vec_b_t tbl_b[5] = '{
    '{16'h1234, 2'b10, 16'h3412}, '{16'h1234, 2'b01, 16'h2C48},
    '{16'h1234, 2'b11, 16'h3412}, '{16'h1234, 2'b00, 16'h1234},
    '{16'h00F1, 2'b01, 16'h8F00}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor A: scoreboard pop on every output transfer, plus hold-stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && a_out_valid) check("a_hold_stable", 32'(a_out_data), 32'(hold_data));
      hold_pend = a_out_valid && !a_out_ready;
      hold_data = a_out_data;
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_beat: got 0x%0h, expected no beat", a_out_data);
        end else begin
          head_a = exp_a.pop_front();
          check("a_data", 32'(a_out_data), 32'(head_a));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_beat: got 0x%0h, expected no beat", b_out_data);
      end else begin
        head_b = exp_b.pop_front();
        check("b_data", 32'(b_out_data), 32'(head_b));
      end
    end
  end

  // Drivers start at posedge+1 and return at posedge+1 after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic [1:0] m, input logic [7:0] e);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_mode  = m;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!a_in_ready) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end else begin
      exp_a.push_back(e);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_in_data  = ~d;
    a_in_mode  = ~m;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [1:0] m, input logic [15:0] e);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_mode  = m;
    @(negedge clk);
    while (!b_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!b_in_ready) begin
      checks++;
      errors++;
      $display("FAIL b_accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end else begin
      exp_b.push_back(e);
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_data  = ~d;
    b_in_mode  = ~m;
  endtask

  task automatic wait_drain_a();
    int n = 0;
    while (exp_a.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("a_drain_left", 32'(exp_a.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("b_drain_left", 32'(exp_b.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_a.delete();
    exp_b.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    time t0, t1;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
    stress_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_a_out_data",  32'(a_out_data),  32'd0);
    check("rst_a_beat_cnt",  32'(a_beat_cnt),  32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_beat_cnt",  32'(b_beat_cnt),  32'd0);
    rst = 1'b0;

    // First beat right after reset: accepted on the first edge, visible one edge later.
    t0 = $time;
    send_a(8'h01, 2'b01, 8'h80);
    t1 = $time;
    check("a_first_accept_time", 32'(t1 - t0), 32'(PERIOD));
    check("a_latency_valid", 32'(a_out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("a_cnt_after_one", 32'(a_beat_cnt), 32'd1);
    check("a_valid_drops", 32'(a_out_valid), 32'd0);

    foreach (tbl_b[i]) send_b(tbl_b[i].d, tbl_b[i].m, tbl_b[i].e);
    wait_drain_b();
    check("b_cnt", 32'(b_beat_cnt), 32'd5);

    t0 = $time;
    foreach (tbl_a[i]) send_a(tbl_a[i].d, tbl_a[i].m, tbl_a[i].e);
    t1 = $time;
    check("a_throughput", 32'(t1 - t0), 32'(7 * PERIOD));
    wait_drain_a();
    check("a_cnt_after_table", 32'(a_beat_cnt), 32'd8);

    // Backpressure: two beats fill main+skid, the third is held off.
    do_reset();
    a_out_ready = 1'b0;
    send_a(8'h11, 2'b00, 8'h11);
    send_a(8'h22, 2'b00, 8'h22);
    check("bp_in_ready_low", 32'(a_in_ready), 32'd0);
    a_in_valid = 1'b1; a_in_data = 8'h33; a_in_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_held", 32'(a_in_ready), 32'd0);
    check("bp_cnt_held", 32'(a_beat_cnt), 32'd0);
    check("bp_out_data_held", 32'(a_out_data), 32'h11);
    a_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_back", 32'(a_in_ready), 32'd1);
    exp_a.push_back(8'h33);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check("bp_no_gap", 32'(a_out_valid), 32'd1);
    wait_drain_a();
    check("bp_cnt_final", 32'(a_beat_cnt), 32'd3);

    // Reset with both registers full and a transfer pending on the same edge.
    a_out_ready = 1'b0;
    send_a(8'h44, 2'b00, 8'h44);
    send_a(8'h55, 2'b00, 8'h55);
    check("full_in_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    do_reset();
    check("midrst_out_valid", 32'(a_out_valid), 32'd0);
    check("midrst_in_ready", 32'(a_in_ready), 32'd1);
    check("midrst_cnt", 32'(a_beat_cnt), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(a_out_valid), 32'd0);

    // 17 transfers on a 4-bit counter wrap to 1.
    t0 = $time;
    for (int i = 0; i < 17; i++) send_a(8'(i + 8'h40), 2'b00, 8'(i + 8'h40));
    t1 = $time;
    check("wrap_throughput", 32'(t1 - t0), 32'(17 * PERIOD));
    wait_drain_a();
    check("wrap_cnt", 32'(a_beat_cnt), 32'd1);

    // Random valid/ready stress; 40 transfers leave the counter at 8.
    do_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] d;
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          d = 8'($urandom_range(0, 255));
          send_a(d, 2'b00, d);
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk);
          #1;
          a_out_ready = 1'($urandom_range(0, 1));
        end
        a_out_ready = 1'b1;
      end
    join
    wait_drain_a();
    check("stress_cnt", 32'(a_beat_cnt), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
